// File: rtl/awg_cmd_ctrl_pkg.sv
// Shared constants, types and decode helpers for the AWG command controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package awg_cmd_pkg;

  // ASCII bytes recognised by the command parser
  localparam logic [7:0] CH_W    = 8'h77;
  localparam logic [7:0] CH_F    = 8'h66;
  localparam logic [7:0] CH_A    = 8'h61;
  localparam logic [7:0] CH_P    = 8'h70;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_SEMI = 8'h3B;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  typedef enum logic [1:0] {FLD_WAVE, FLD_FREQ, FLD_AMP, FLD_PHASE} field_e;

  // Decimal accumulator: 17 bits, saturating
  localparam int             ACC_W   = 17;
  localparam logic [ACC_W-1:0] ACC_SAT = 17'h1FFFF;

  localparam logic [ACC_W-1:0] MAX_WAVE  = 17'd4;
  localparam logic [ACC_W-1:0] MAX_FREQ  = 17'd4095;
  localparam logic [ACC_W-1:0] MAX_AMP   = 17'd7;
  localparam logic [ACC_W-1:0] MAX_PHASE = 17'd255;

  typedef struct packed {
    logic [2:0]  wave;
    logic [11:0] freq;
    logic [2:0]  amp;
    logic [7:0]  phase;
  } cfg_t;

  localparam cfg_t CFG_RST = '{wave: 3'd0, freq: 12'd1, amp: 3'd4, phase: 8'd0};

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CHAR    = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  function automatic logic is_digit(logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

  function automatic logic is_header(logic [7:0] b);
    return (b == CH_W) || (b == CH_F) || (b == CH_A) || (b == CH_P);
  endfunction

  function automatic logic is_blank(logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF) || (b == CH_SP);
  endfunction

  function automatic field_e header_field(logic [7:0] b);
    case (b)
      CH_F:    return FLD_FREQ;
      CH_A:    return FLD_AMP;
      CH_P:    return FLD_PHASE;
      default: return FLD_WAVE;
    endcase
  endfunction

  function automatic logic [ACC_W-1:0] field_max(field_e f);
    case (f)
      FLD_WAVE: return MAX_WAVE;
      FLD_FREQ: return MAX_FREQ;
      FLD_AMP:  return MAX_AMP;
      default:  return MAX_PHASE;
    endcase
  endfunction

endpackage

// File: rtl/awg_cmd_ctrl_if.sv
// Byte input, DDS wrap strobe and active configuration of the command controller.
// Latency: n/a (wiring only).
// Backpressure: none; the UART byte strobe is fire-and-forget.
interface awg_cmd_ctrl_if;
  logic [7:0]  cmd;
  logic        rd;
  logic        phase_wrap;
  logic [2:0]  state;
  logic [11:0] state_freq;
  logic [2:0]  state_amp;
  logic [7:0]  state_phase;
  logic        cfg_update;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  modport master (
    output cmd, rd, phase_wrap,
    input  state, state_freq, state_amp, state_phase, cfg_update, err, err_code, busy
  );

  modport slave (
    input  cmd, rd, phase_wrap,
    output state, state_freq, state_amp, state_phase, cfg_update, err, err_code, busy
  );
endinterface

// File: rtl/awg_cmd_ctrl_rd_sync_edge.sv
// Brings the asynchronous UART byte strobe into clk and emits a one-cycle pulse per rise.
// Latency: pulse is consumed on the 3rd clk edge after the input rises.
// Backpressure: none; a rise is never held off or queued.
module rd_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);
  logic [2:0] sr;

  // Two synchronizer stages plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[1:0], async_in};
  end

  assign pulse = sr[1] & ~sr[2];
endmodule

// File: rtl/awg_cmd_ctrl.sv
// Parses framed UART commands into shadow config and applies it atomically to the DDS.
// Latency: byte effect 3 clk after rd rise; shadows reach outputs at the next phase_wrap.
// Backpressure: none; bytes are consumed as they arrive, bad ones are reported on err.
module awg_cmd_ctrl
  import awg_cmd_pkg::*;
#(
  parameter bit SYNC_APPLY  = 1'b1,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int MAX_DIGITS  = 5
) (
  input logic           clk,
  input logic           rst_n,
  awg_cmd_ctrl_if.slave bus
);
  localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
  localparam int TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int MUL_W  = ACC_W + 4;

  logic              byte_v;
  logic [0:0]        fsm, fsm_nxt;
  field_e            fld, fld_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt;
  logic              ovf, ovf_nxt;
  logic [NDIG_W-1:0] ndig, ndig_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic [MUL_W-1:0]  acc_mul;
  logic              term_bad;
  cfg_t              shd, shd_nxt, act;
  logic              commit, apply, pending, cfg_update;
  logic              err_hit, err;
  logic [1:0]        err_val, err_code;

  rd_sync_edge u_rd_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.rd),
    .pulse    (byte_v)
  );

  // Digit values are the low nibble of '0'..'9'
  assign acc_mul  = MUL_W'(acc) * MUL_W'(10) + MUL_W'(bus.cmd[3:0]);
  assign term_bad = (ndig == '0) || ovf || (acc > field_max(fld)) ||
                    ((fld == FLD_FREQ) && (acc == '0));
  assign tmo_hit  = (fsm == ST_ACC) && !byte_v && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  // A commit in the apply cycle lands one wrap later: apply copies the old shadows
  assign apply    = pending && (bus.phase_wrap || !SYNC_APPLY);

  // Byte decode: next parser state, shadow writes and error reporting
  always_comb begin
    fsm_nxt  = fsm;
    fld_nxt  = fld;
    acc_nxt  = acc;
    ovf_nxt  = ovf;
    ndig_nxt = ndig;
    shd_nxt  = shd;
    commit   = 1'b0;
    err_hit  = 1'b0;
    err_val  = err_code;
    if (byte_v) begin
      if (fsm == ST_IDLE) begin
        if (is_header(bus.cmd)) begin
          fsm_nxt  = ST_ACC;
          fld_nxt  = header_field(bus.cmd);
          acc_nxt  = '0;
          ovf_nxt  = 1'b0;
          ndig_nxt = '0;
        end else if (bus.cmd == CH_R) begin
          shd_nxt = CFG_RST;
          commit  = 1'b1;
        end else if (!is_blank(bus.cmd)) begin
          err_hit = 1'b1;
          err_val = ERR_CHAR;
        end
      end else if (is_digit(bus.cmd)) begin
        if (ndig == NDIG_W'(MAX_DIGITS)) begin
          err_hit = 1'b1;
          err_val = ERR_RANGE;
          fsm_nxt = ST_IDLE;
        end else begin
          if (acc_mul > MUL_W'(ACC_SAT)) begin
            acc_nxt = ACC_SAT;
            ovf_nxt = 1'b1;
          end else begin
            acc_nxt = acc_mul[ACC_W-1:0];
          end
          ndig_nxt = ndig + 1'b1;
        end
      end else if ((bus.cmd == CH_SEMI) || (bus.cmd == CH_CR)) begin
        fsm_nxt = ST_IDLE;
        if (term_bad) begin
          err_hit = 1'b1;
          err_val = ERR_RANGE;
        end else begin
          commit = 1'b1;
          case (fld)
            FLD_WAVE: shd_nxt.wave  = acc[2:0];
            FLD_FREQ: shd_nxt.freq  = acc[11:0];
            FLD_AMP:  shd_nxt.amp   = acc[2:0];
            default:  shd_nxt.phase = acc[7:0];
          endcase
        end
      end else begin
        // Any non-digit, non-terminator aborts; it is not re-parsed as a new header
        err_hit = 1'b1;
        err_val = ERR_CHAR;
        fsm_nxt = ST_IDLE;
      end
    end else if (tmo_hit) begin
      err_hit = 1'b1;
      err_val = ERR_TIMEOUT;
      fsm_nxt = ST_IDLE;
    end
  end

  // Parser registers, shadow config and the error pulse/code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= ST_IDLE;
      fld      <= FLD_WAVE;
      acc      <= '0;
      ovf      <= 1'b0;
      ndig     <= '0;
      shd      <= CFG_RST;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      fsm      <= fsm_nxt;
      fld      <= fld_nxt;
      acc      <= acc_nxt;
      ovf      <= ovf_nxt;
      ndig     <= ndig_nxt;
      shd      <= shd_nxt;
      err      <= err_hit;
      err_code <= err_val;
    end
  end

  // Inter-byte idle counter, only meaningful while a field is being accumulated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     tmo_cnt <= '0;
    else if (byte_v || (fsm != ST_ACC) || tmo_hit) tmo_cnt <= '0;
    else                                            tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Atomic apply of all four fields; later commits simply overwrite the shadows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act        <= CFG_RST;
      pending    <= 1'b0;
      cfg_update <= 1'b0;
    end else begin
      if (apply) act <= shd;
      cfg_update <= apply;
      if (commit)     pending <= 1'b1;
      else if (apply) pending <= 1'b0;
    end
  end

  assign bus.state       = act.wave;
  assign bus.state_freq  = act.freq;
  assign bus.state_amp   = act.amp;
  assign bus.state_phase = act.phase;
  assign bus.cfg_update  = cfg_update;
  assign bus.err         = err;
  assign bus.err_code    = err_code;
  assign bus.busy        = (fsm == ST_ACC);
endmodule
